// File: rtl/hilo_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit_pkg
//  Description : Shared ALU op encodings plus the HI/LO unit state encodings
//                and default multiply/divide latencies.
//  Contents    : ALU_* op codes (5-bit), hilo_state_e, latency defaults,
//                counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_unit_pkg;

    // ALU op encodings driven on sig_alu_control by the decode stage.
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;
    localparam logic [4:0] ALU_MULT = 5'd11;
    localparam logic [4:0] ALU_DIV  = 5'd12;

    // Default cycles from mult/div acceptance to HI/LO commit.
    localparam int unsigned DEFAULT_MULT_CYCLES = 4;
    localparam int unsigned DEFAULT_DIV_CYCLES  = 16;

    // Latency counter width; latencies are limited to 1..31.
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        HILO_IDLE      = 2'd0,
        HILO_MULT_BUSY = 2'd1,
        HILO_DIV_BUSY  = 2'd2
    } hilo_state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_latency_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_latency_counter
//  Description : Loadable down-counter timing a mult/div in flight. Counts
//                down one per cycle and rests at zero.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load            - load load_value this cycle
//                load_value[4:0] - value loaded
//                count_zero      - counter currently at zero
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_latency_counter
    import hilo_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             count_zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit
//  Description : Architectural HI/LO registers with multi-cycle mult/div
//                latency modelling, hazard stall, mfhi/mflo read mux and
//                mthi/mtlo writes.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                ex_valid                    - EX instruction valid
//                sig_alu_control[4:0]        - EX ALU op code
//                src_a, src_b [31:0]         - ALU operands (src_a = mt data)
//                alu_hi, alu_lo [31:0]       - ALU mult/div results
//                ex_is_mfhi/mflo/mthi/mtlo   - decoded HI/LO instruction class
//                hi_q, lo_q [31:0]           - architectural HI/LO
//                mf_data [31:0]              - mfhi/mflo read data
//                busy                        - mult/div in flight
//                stall                       - freeze IF/ID/EX
//                div_zero                    - pulse on rejected divide by 0
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [4:0]  sig_alu_control,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        ex_is_mfhi,
    input  logic        ex_is_mflo,
    input  logic        ex_is_mthi,
    input  logic        ex_is_mtlo,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] mf_data,
    output logic        busy,
    output logic        stall,
    output logic        div_zero
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    hilo_state_e state_q, state_d;
    logic [31:0] hi_d, lo_d;
    logic [31:0] pending_hi_q, pending_hi_d;
    logic [31:0] pending_lo_q, pending_lo_d;
    logic        div_zero_q, div_zero_d;

    logic             op_mult;
    logic             op_div;
    logic             hilo_dep;
    logic             accept;
    logic             start_op;
    logic             commit;
    logic             ex_go;
    logic             count_zero;
    logic [CNT_W-1:0] load_value;

    assign op_mult  = (sig_alu_control == ALU_MULT);
    assign op_div   = (sig_alu_control == ALU_DIV);
    assign busy     = (state_q != HILO_IDLE);

    // Any instruction that reads, writes or restarts HI/LO must wait for
    // the in-flight result, including during the final busy cycle.
    assign hilo_dep = ex_is_mfhi | ex_is_mflo | ex_is_mthi | ex_is_mtlo
                    | op_mult | op_div;
    assign stall    = busy & ex_valid & hilo_dep;
    assign ex_go    = ex_valid & ~stall;
    assign accept   = ex_go & (op_mult | op_div);

    // A divide by zero is accepted (so it leaves EX) but never starts.
    assign start_op = accept & (op_mult | (src_b != 32'd0));
    assign commit   = busy & count_zero;

    assign load_value = op_mult ? MULT_LOAD : DIV_LOAD;

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        div_zero_d   = accept & op_div & (src_b == 32'd0);

        unique case (state_q)
            HILO_IDLE: begin
                if (start_op) begin
                    pending_hi_d = alu_hi;
                    pending_lo_d = alu_lo;
                    state_d      = op_mult ? HILO_MULT_BUSY : HILO_DIV_BUSY;
                end
            end
            HILO_MULT_BUSY, HILO_DIV_BUSY: begin
                if (count_zero) begin
                    state_d = HILO_IDLE;
                end
            end
            default: begin
                state_d = HILO_IDLE;
            end
        endcase

        // mthi/mtlo stall while busy, so they never collide with a commit.
        if (commit) begin
            hi_d = pending_hi_q;
            lo_d = pending_lo_q;
        end else begin
            if (ex_go & ex_is_mthi) begin
                hi_d = src_a;
            end
            if (ex_go & ex_is_mtlo) begin
                lo_d = src_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HILO_IDLE;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            pending_hi_q <= 32'd0;
            pending_lo_q <= 32'd0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            div_zero_q   <= div_zero_d;
        end
    end

    assign div_zero = div_zero_q;

    // Reads see committed state only; pending results are not forwarded.
    assign mf_data = ex_is_mfhi ? hi_q :
                     ex_is_mflo ? lo_q : 32'd0;

    hilo_latency_counter u_latency_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start_op),
        .load_value (load_value),
        .count_zero (count_zero)
    );

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_unit
//  Description : Self-checking bench for hilo_unit. A cycle-level model
//                (remaining-latency integer, pending result, HI/LO values)
//                is compared against every DUT output on each falling edge;
//                directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    localparam int MC = 4;
    localparam int DC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  sig_alu_control = ALU_ADD;
    logic [31:0] src_a = '0, src_b = '0, alu_hi = '0, alu_lo = '0;
    logic        ex_is_mfhi = 1'b0, ex_is_mflo = 1'b0;
    logic        ex_is_mthi = 1'b0, ex_is_mtlo = 1'b0;
    logic [31:0] hi_q, lo_q, mf_data;
    logic        busy, stall, div_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .sig_alu_control (sig_alu_control),
        .src_a           (src_a),
        .src_b           (src_b),
        .alu_hi          (alu_hi),
        .alu_lo          (alu_lo),
        .ex_is_mfhi      (ex_is_mfhi),
        .ex_is_mflo      (ex_is_mflo),
        .ex_is_mthi      (ex_is_mthi),
        .ex_is_mtlo      (ex_is_mtlo),
        .hi_q            (hi_q),
        .lo_q            (lo_q),
        .mf_data         (mf_data),
        .busy            (busy),
        .stall           (stall),
        .div_zero        (div_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_rem = 0;          // busy cycles still to run; 0 = idle
    logic        m_dz = 1'b0;

    wire m_is_mul = (sig_alu_control == ALU_MULT);
    wire m_is_div = (sig_alu_control == ALU_DIV);
    wire m_stall  = (m_rem != 0) && ex_valid &&
                    (ex_is_mfhi || ex_is_mflo || ex_is_mthi || ex_is_mtlo || m_is_mul || m_is_div);
    wire m_go     = ex_valid && !m_stall;
    wire m_acc    = m_go && (m_is_mul || m_is_div);
    wire m_dz0    = m_acc && m_is_div && (src_b == 32'd0);
    wire [31:0] m_mf = ex_is_mfhi ? m_hi : (ex_is_mflo ? m_lo : 32'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0;
            m_rem <= 0; m_dz <= 1'b0;
        end else begin
            m_dz <= m_dz0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi <= m_phi;
                    m_lo <= m_plo;
                end
            end else if (m_acc && !m_dz0) begin
                m_phi <= alu_hi;
                m_plo <= alu_lo;
                m_rem <= m_is_mul ? MC : DC;
            end
            if (m_go && ex_is_mthi) m_hi <= src_a;
            if (m_go && ex_is_mtlo) m_lo <= src_a;
        end
    end

    always @(negedge clk) begin
        chk("hi_q",     hi_q,           m_hi);
        chk("lo_q",     lo_q,           m_lo);
        chk("mf_data",  mf_data,        m_mf);
        chk("busy",     32'(busy),      32'(m_rem != 0));
        chk("stall",    32'(stall),     32'(m_stall));
        chk("div_zero", 32'(div_zero),  32'(m_dz));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; sig_alu_control = ALU_ADD;
        ex_is_mfhi = 1'b0; ex_is_mflo = 1'b0; ex_is_mthi = 1'b0; ex_is_mtlo = 1'b0;
    endtask

    task automatic op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] h, input logic [31:0] l);
        idle();
        ex_valid = 1'b1; sig_alu_control = code;
        src_a = a; src_b = b; alu_hi = h; alu_lo = l;
    endtask

    // Count cycles while busy stays high (bounded).
    task automatic busy_cycles(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            cyc();
        end
    endtask

    int n;
    int dz_cnt, bz_cnt;

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_hi",   hi_q,      32'd0);
        chk("reset_lo",   lo_q,      32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Reset in the middle of a multiply.
        op(ALU_MULT, 32'd0, 32'd0, 32'hAAAA_AAAA, 32'h5555_5555);
        cyc();
        idle();
        cyc();
        chk("midop_busy_before", 32'(busy), 32'd1);
        ex_valid = 1'b1; ex_is_mfhi = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midop_hi",    hi_q,       32'd0);
        chk("midop_lo",    lo_q,       32'd0);
        chk("midop_busy",  32'(busy),  32'd0);
        chk("midop_stall", 32'(stall), 32'd0);
        cyc();
        idle();
        rst_n = 1'b1;
        repeat (6) cyc();
        chk("midop_no_commit_hi", hi_q, 32'd0);

        // Multiply latency: -2 * 3.
        op(ALU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        cyc();
        idle();
        busy_cycles(n);
        chk("mult_busy_len", 32'(n), 32'd4);
        chk("mult_hi", hi_q, 32'hFFFF_FFFF);
        chk("mult_lo", lo_q, 32'hFFFF_FFFA);

        // Unknown op code is ignored.
        op(5'h1F, 32'd9, 32'd9, 32'h1, 32'h2);
        cyc();
        chk("unknown_busy", 32'(busy), 32'd0);
        chk("unknown_hi",   hi_q,      32'hFFFF_FFFF);

        // Divide 7/2 with an mflo right behind it.
        op(ALU_DIV, 32'd7, 32'd2, 32'd1, 32'd3);
        cyc();
        idle();
        ex_valid = 1'b1; ex_is_mflo = 1'b1;
        n = 0;
        while (stall && n < 64) begin
            n++;
            cyc();
        end
        chk("div_stall_len", 32'(n),    32'd16);
        chk("div_mflo",      mf_data,   32'd3);
        chk("div_hi",        hi_q,      32'd1);
        chk("div_busy_done", 32'(busy), 32'd0);
        cyc();
        idle();

        // Divide by zero.
        op(ALU_DIV, 32'd5, 32'd0, 32'hDEAD_DEAD, 32'hBEEF_BEEF);
        chk("dz_before", 32'(div_zero), 32'd0);
        cyc();
        idle();
        dz_cnt = 0; bz_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            dz_cnt += int'(div_zero);
            bz_cnt += int'(busy);
            cyc();
        end
        chk("dz_pulses", 32'(dz_cnt), 32'd1);
        chk("dz_busy",   32'(bz_cnt), 32'd0);
        chk("dz_hi",     hi_q,        32'd1);
        chk("dz_lo",     lo_q,        32'd3);

        // mthi / mtlo while idle.
        idle(); ex_valid = 1'b1; ex_is_mthi = 1'b1; src_a = 32'h1234_5678;
        cyc();
        idle(); ex_valid = 1'b1; ex_is_mtlo = 1'b1; src_a = 32'h9ABC_DEF0;
        cyc();
        chk("mthi_hi", hi_q, 32'h1234_5678);
        idle(); ex_valid = 1'b1; ex_is_mfhi = 1'b1;
        #1;
        chk("mfhi_data", mf_data, 32'h1234_5678);
        chk("mtlo_lo",   lo_q,    32'h9ABC_DEF0);
        cyc();

        // Flushed second mult does not stall; first still commits.
        op(ALU_MULT, 32'd0, 32'd0, 32'h11, 32'h22);
        cyc();
        op(ALU_MULT, 32'd0, 32'd0, 32'h33, 32'h44);
        ex_valid = 1'b0;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        busy_cycles(n);
        chk("flush_busy_len", 32'(n), 32'd4);
        chk("flush_hi",       hi_q,   32'h11);
        chk("flush_lo",       lo_q,   32'h22);
        ex_valid = 1'b1;
        #1;
        chk("b2b_first_idle_stall", 32'(stall), 32'd0);
        cyc();
        chk("b2b_accepted", 32'(busy), 32'd1);

        // Third mult right behind: stalls for the full latency, then goes.
        alu_hi = 32'h55; alu_lo = 32'h66;
        n = 0;
        while (stall && n < 64) begin
            n++;
            cyc();
        end
        chk("b2b_stall_len", 32'(n), 32'd4);
        chk("b2b_hi",        hi_q,   32'h33);
        cyc();
        chk("b2b_third_busy", 32'(busy), 32'd1);
        idle();
        busy_cycles(n);
        chk("b2b_third_hi", hi_q, 32'h55);
        chk("b2b_third_lo", lo_q, 32'h66);

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sits directly downstream of the EX-stage ALU and consumes its hi/lo outputs for mult/div.
- Holds the architectural HI and LO registers.
- Models multi-cycle mult/div latency with a busy counter.
- Stalls the pipeline when a HI/LO-dependent instruction reaches EX while an operation is in flight. Services mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 4, cycles from mult acceptance to HI/LO commit (legal range 1..31).
- DIV_CYCLES, 16, cycles from div acceptance to HI/LO commit (legal range 1..31).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX-stage instruction is valid and not flushed.
- sig_alu_control  input  5  ALU op code of the EX instruction (shared ALU_* encodings).
- src_a  input  32  ALU operand A; also the mthi/mtlo write data.
- src_b  input  32  ALU operand B; used only for divide-by-zero detection.
- alu_hi  input  32  ALU hi result for mult/div.
- alu_lo  input  32  ALU lo result for mult/div.
- ex_is_mfhi, ex_is_mflo, ex_is_mthi, ex_is_mtlo  input  1 each  decoded EX instruction class (at most one high).
- hi_q  output  32  architectural HI.
- lo_q  output  32  architectural LO.
- mf_data  output  32  HI when ex_is_mfhi, LO when ex_is_mflo, else 0.
- busy  output  1  mult/div in flight.
- stall  output  1  freeze IF/ID/EX this cycle.
- div_zero  output  1  one-cycle pulse on a rejected divide by zero.

Behaviour:
- Reset (async, rst_n=0):
  - hi_q=0, lo_q=0, pending registers=0, counter=0.
  - State=IDLE; busy=0, div_zero=0.
  - An in-flight operation is discarded.
- States IDLE, MULT_BUSY, DIV_BUSY. busy=1 in both BUSY states.
- Acceptance condition: "accept" = ex_valid & ~stall & op in {ALU_mult, ALU_div}.
- IDLE, accept mult:
  - Latch alu_hi/alu_lo into pending_hi/pending_lo.
  - Load counter=MULT_CYCLES-1; go to MULT_BUSY.
- IDLE, accept div with src_b!=0: same as mult, but counter=DIV_CYCLES-1 and go to DIV_BUSY.
- IDLE, accept div with src_b==0:
  - HI/LO unchanged, state stays IDLE.
  - div_zero=1 for the following cycle only.
- BUSY:
  - counter decrements each cycle.
  - On the edge where counter==0: hi_q<=pending_hi, lo_q<=pending_lo, go to IDLE.
  - Total latency = N cycles from the accept edge to HI/LO visible (N=MULT_CYCLES or DIV_CYCLES).
- stall (combinational) = busy & ex_valid & (ex_is_mfhi | ex_is_mflo | ex_is_mthi | ex_is_mtlo | op is mult/div).
  - Stall is also asserted during the final busy cycle; the dependent instruction proceeds in the first IDLE cycle and reads committed values.
  - Non-HI/LO instructions never stall.
- mthi/mtlo:
  - When ex_valid & ~stall, write src_a to hi_q (mthi) or lo_q (mtlo) at the next edge.
  - Never coincides with a commit because of the stall rule.
- mf_data is combinational from hi_q/lo_q. No forwarding from pending registers.
- ex_valid=0 (flush or bubble): nothing accepted, no stall. An in-flight op is not aborted and still commits.
- Back-to-back mult after mult: the second stalls until IDLE, then is accepted in that cycle.
- Unknown op codes are ignored.

Decomposition:
- Shared include header (the same one holding the ALU_* op encodings) gains:
  - HILO state encodings: HILO_IDLE, HILO_MULT_BUSY, HILO_DIV_BUSY.
  - Default latency constants.
- One sub-module: hilo_latency_counter.
  - 5-bit loadable down-counter; inputs load, load_value; outputs count_zero.
  - Instantiated once.

Test Plan:
- Reset mid-operation: accept mult, assert rst_n=0 on cycle 2 -> hi_q=0, lo_q=0, busy=0 immediately; stall=0; no later commit.
- Mult latency (MULT_CYCLES=4): accept mult with alu_hi=0xFFFFFFFF, alu_lo=0xFFFFFFFA (i.e. -2*3) -> busy=1 for exactly 4 cycles; hi_q/lo_q update on the 4th edge.
- Read hazard: mflo presented the cycle after a div accept (DIV_CYCLES=16) -> stall=1 for 16 cycles, including the final busy cycle. On the 17th cycle, mf_data = committed lo (src_a=7, src_b=2 -> lo=3, hi=1).
- Divide by zero: div with src_a=5, src_b=0 -> busy stays 0, HI/LO unchanged, div_zero pulses exactly one cycle.
- mthi/mtlo while idle: mthi src_a=0x12345678, then mtlo src_a=0x9ABCDEF0 -> hi_q/lo_q hold those values one edge later; a subsequent mfhi gives mf_data=0x12345678.
- Flush and back-to-back: mult in flight, EX holds a second mult with ex_valid=0 -> no stall, first commits. Then ex_valid=1 with a mult -> accepted in the first IDLE cycle.
